// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        RstSeqHold    = 2'd0,
        RstSeqRelease = 2'd1,
        RstSeqDone    = 2'd2
    } rst_seq_state_e;

endpackage

// File: rtl/rst_sync_release.sv
// Reset synchroniser: asserts asynchronously, releases after Stages clock edges.
module rst_sync_release #(
    parameter int unsigned Stages = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic released_o
);

    logic [Stages-1:0] chain_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[Stages-2:0], 1'b1};
        end
    end

    assign released_o = chain_q[Stages-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: one raw reset in, NumDomains active-low domain resets out,
// released in ascending order with programmable spacing; supports masked software re-sequencing.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int unsigned            NumDomains = 3,
    parameter int unsigned            HoldCycles = 16,
    parameter int unsigned            StageDelay = 8,
    parameter int unsigned            SyncStages = 2,
    parameter int unsigned            CntWidth   = 8,
    parameter logic [NumDomains-1:0]  SwRstMask  = {NumDomains{1'b1}}
) (
    input  logic                              clk_sys_i,
    input  logic                              rst_sys_i,
    input  logic                              sw_rst_req_i,
    input  logic                              hold_i,
    output logic [NumDomains-1:0]             rst_no,
    output logic                              rst_done_o,
    output logic [$clog2(NumDomains+1)-1:0]   stage_o
);

    localparam int unsigned StageW = $clog2(NumDomains + 1);
    localparam logic [CntWidth-1:0] HoldLast  = CntWidth'(HoldCycles - 1);
    localparam logic [CntWidth-1:0] StageLast = CntWidth'(StageDelay - 1);
    localparam logic [StageW-1:0]   LastStage = StageW'(NumDomains - 1);

    if (NumDomains < 1 || NumDomains > 8) begin : g_bad_domains
        $error("rst_seq_ctrl: NumDomains must be 1..8");
    end
    if (HoldCycles < 1 || StageDelay < 1 || SyncStages < 2) begin : g_bad_timing
        $error("rst_seq_ctrl: HoldCycles/StageDelay must be >=1, SyncStages >=2");
    end
    if (HoldCycles >= (2 ** CntWidth) || StageDelay >= (2 ** CntWidth)) begin : g_bad_cnt
        $error("rst_seq_ctrl: CntWidth too small for HoldCycles/StageDelay");
    end

    rst_seq_state_e            state_q, state_d;
    logic [CntWidth-1:0]       cnt_q, cnt_d;
    logic [StageW-1:0]         stage_q, stage_d;
    logic [NumDomains-1:0]     rst_n_q, rst_n_d;
    logic                      released;

    rst_sync_release #(
        .Stages (SyncStages)
    ) u_sync (
        .clk_i      (clk_sys_i),
        .rst_i      (rst_sys_i),
        .released_o (released)
    );

    // Every slot releases its domain; a domain skipped by the software mask is
    // already high, so the write is a no-op but the slot's time still elapses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        rst_n_d = rst_n_q;
        unique case (state_q)
            RstSeqHold: begin
                if (!hold_i) begin
                    if (cnt_q == HoldLast) begin
                        state_d = RstSeqRelease;
                        cnt_d   = '0;
                        stage_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RstSeqRelease: begin
                if (cnt_q == StageLast) begin
                    cnt_d   = '0;
                    stage_d = stage_q + 1'b1;
                    for (int i = 0; i < NumDomains; i++) begin
                        if (stage_q == StageW'(i)) begin
                            rst_n_d[i] = 1'b1;
                        end
                    end
                    if (stage_q == LastStage) begin
                        state_d = RstSeqDone;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RstSeqDone: begin
                if (sw_rst_req_i) begin
                    state_d = RstSeqHold;
                    cnt_d   = '0;
                    stage_d = '0;
                    rst_n_d = rst_n_q & ~SwRstMask;
                end
            end
            default: begin
                state_d = RstSeqHold;
                cnt_d   = '0;
                stage_d = '0;
                rst_n_d = '0;
            end
        endcase
    end

    // The FSM stays frozen until the release synchroniser has shifted in a 1.
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            state_q <= RstSeqHold;
            cnt_q   <= '0;
            stage_q <= '0;
            rst_n_q <= '0;
        end else if (released) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            rst_n_q <= rst_n_d;
        end
    end

    assign rst_no     = rst_n_q;
    assign rst_done_o = (state_q == RstSeqDone);
    assign stage_o    = stage_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: default instance with software mask 3'b110,
// plus a minimal single-domain instance.
module tb_rst_seq_ctrl;

    logic       clk;
    logic       rst_a;
    logic       hold_a;
    logic       sw_a;
    logic [2:0] rst_no_a;
    logic       done_a;
    logic [1:0] stage_a;

    logic       rst_b;
    logic       hold_b;
    logic       sw_b;
    logic [0:0] rst_no_b;
    logic       done_b;
    logic [0:0] stage_b;

    int total;
    int bad;

    // Edge index (1-based from the start of a watch window) of first rise/fall.
    int rise_e[3];
    int fall_e[3];
    int done_rise[4];
    int done_fall[4];

    rst_seq_ctrl #(
        .SwRstMask (3'b110)
    ) u_dut_a (
        .clk_sys_i    (clk),
        .rst_sys_i    (rst_a),
        .sw_rst_req_i (sw_a),
        .hold_i       (hold_a),
        .rst_no       (rst_no_a),
        .rst_done_o   (done_a),
        .stage_o      (stage_a)
    );

    rst_seq_ctrl #(
        .NumDomains (1),
        .HoldCycles (1),
        .StageDelay (1),
        .SyncStages (2)
    ) u_dut_b (
        .clk_sys_i    (clk),
        .rst_sys_i    (rst_b),
        .sw_rst_req_i (sw_b),
        .hold_i       (hold_b),
        .rst_no       (rst_no_b),
        .rst_done_o   (done_b),
        .stage_o      (stage_b)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // driver: runs ncyc edges on instance A, driving hold_i high for edges
    // hold_from..hold_to and sw_rst_req_i high for edges 1..sw_to, and records
    // the edge at which each output first changes. Called at a negedge.
    task automatic watch_a(input int ncyc, input int hold_from, input int hold_to,
                           input int sw_to);
        logic [2:0] prev_rst;
        logic       prev_done;
        int         nr;
        int         nf;
        nr = 0;
        nf = 0;
        for (int i = 0; i < 3; i++) begin
            rise_e[i] = -1;
            fall_e[i] = -1;
        end
        for (int i = 0; i < 4; i++) begin
            done_rise[i] = -1;
            done_fall[i] = -1;
        end
        prev_rst  = rst_no_a;
        prev_done = done_a;
        for (int n = 1; n <= ncyc; n++) begin
            hold_a = (n >= hold_from) && (n <= hold_to);
            sw_a   = (n <= sw_to);
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!prev_rst[i] && rst_no_a[i] && rise_e[i] < 0) rise_e[i] = n;
                if (prev_rst[i] && !rst_no_a[i] && fall_e[i] < 0) fall_e[i] = n;
            end
            if (!prev_done && done_a && nr < 4) begin
                done_rise[nr] = n;
                nr++;
            end
            if (prev_done && !done_a && nf < 4) begin
                done_fall[nf] = n;
                nf++;
            end
            prev_rst  = rst_no_a;
            prev_done = done_a;
        end
        hold_a = 1'b0;
        sw_a   = 1'b0;
    endtask

    task automatic pulse_reset_a();
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        hold_a = 1'b0;
        sw_a   = 1'b0;
        hold_b = 1'b0;
        sw_b   = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (rst_no_a !== 3'b000) begin
            bad++;
            $display("FAIL reset_rst_no: got %b want 000", rst_no_a);
        end
        total++;
        if (done_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_done: got %b want 0", done_a);
        end
        total++;
        if (stage_a !== 2'd0) begin
            bad++;
            $display("FAIL reset_stage: got %0d want 0", stage_a);
        end
        total++;
        if (rst_no_b !== 1'b0 || done_b !== 1'b0) begin
            bad++;
            $display("FAIL reset_b: got rst_no=%b done=%b want 0 0", rst_no_b, done_b);
        end
    endtask

    // Domains rise at 2+16+8=26, 34, 42 edges after release.
    task automatic check_full_seq(input string tag, input int base);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rise_e[i] !== base + 8 * i) begin
                bad++;
                $display("FAIL %s_rise%0d: got %0d want %0d", tag, i, rise_e[i], base + 8 * i);
            end
        end
        total++;
        if (done_rise[0] !== base + 16) begin
            bad++;
            $display("FAIL %s_done_at: got %0d want %0d", tag, done_rise[0], base + 16);
        end
        total++;
        if (stage_a !== 2'd3 || rst_no_a !== 3'b111 || done_a !== 1'b1) begin
            bad++;
            $display("FAIL %s_final: got stage=%0d rst_no=%b done=%b want 3 111 1",
                     tag, stage_a, rst_no_a, done_a);
        end
    endtask

    task automatic test_power_on();
        rst_a = 1'b0;
        watch_a(46, 0, -1, 0);
        check_full_seq("power_on", 26);
    endtask

    task automatic test_hold_gate();
        pulse_reset_a();
        watch_a(56, 5, 14, 0);
        check_full_seq("hold_gate", 36);
    endtask

    // Mask 110: domains 1,2 re-sequence; domain 0's slot still elapses, so
    // bit1 rises at 1+16+8+8=33 and bit2 at 41.
    task automatic test_sw_reset();
        watch_a(46, 0, -1, 1);
        total++;
        if (fall_e[1] !== 1 || fall_e[2] !== 1) begin
            bad++;
            $display("FAIL sw_assert: got fall1=%0d fall2=%0d want 1 1", fall_e[1], fall_e[2]);
        end
        total++;
        if (fall_e[0] !== -1) begin
            bad++;
            $display("FAIL sw_bit0_kept: got fall at %0d want none", fall_e[0]);
        end
        total++;
        if (rise_e[1] !== 33 || rise_e[2] !== 41) begin
            bad++;
            $display("FAIL sw_release: got %0d %0d want 33 41", rise_e[1], rise_e[2]);
        end
        total++;
        if (done_fall[0] !== 1 || done_rise[0] !== 41) begin
            bad++;
            $display("FAIL sw_done: got fall=%0d rise=%0d want 1 41", done_fall[0], done_rise[0]);
        end
        total++;
        if (stage_a !== 2'd3 || rst_no_a !== 3'b111) begin
            bad++;
            $display("FAIL sw_final: got stage=%0d rst_no=%b want 3 111", stage_a, rst_no_a);
        end
    endtask

    // Request held for 90 edges: sequences of 40 edges separated by one DONE cycle.
    task automatic test_back_to_back();
        watch_a(130, 0, -1, 90);
        total++;
        if (done_rise[0] !== 41 || done_rise[1] !== 82 || done_rise[2] !== 123) begin
            bad++;
            $display("FAIL b2b_done_rise: got %0d %0d %0d want 41 82 123",
                     done_rise[0], done_rise[1], done_rise[2]);
        end
        total++;
        if (done_fall[0] !== 1 || done_fall[1] !== 42 || done_fall[2] !== 83) begin
            bad++;
            $display("FAIL b2b_done_fall: got %0d %0d %0d want 1 42 83",
                     done_fall[0], done_fall[1], done_fall[2]);
        end
        total++;
        if (fall_e[0] !== -1 || done_a !== 1'b1) begin
            bad++;
            $display("FAIL b2b_end: got bit0_fall=%0d done=%b want none 1", fall_e[0], done_a);
        end
    endtask

    task automatic test_async_mid();
        pulse_reset_a();
        watch_a(30, 0, -1, 0);
        total++;
        if (stage_a !== 2'd1 || rst_no_a !== 3'b001) begin
            bad++;
            $display("FAIL mid_pre: got stage=%0d rst_no=%b want 1 001", stage_a, rst_no_a);
        end
        #2;
        rst_a = 1'b1;
        #1;
        total++;
        if (rst_no_a !== 3'b000 || done_a !== 1'b0 || stage_a !== 2'd0) begin
            bad++;
            $display("FAIL mid_async: got rst_no=%b done=%b stage=%0d want 000 0 0",
                     rst_no_a, done_a, stage_a);
        end
        @(negedge clk);
        rst_a = 1'b0;
        watch_a(46, 0, -1, 0);
        check_full_seq("mid_repeat", 26);
    endtask

    task automatic test_single_domain();
        int rise_b;
        rise_b = -1;
        rst_b  = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (rst_no_b[0] && rise_b < 0) rise_b = n;
        end
        total++;
        if (rise_b !== 4) begin
            bad++;
            $display("FAIL single_rise: got %0d want 4", rise_b);
        end
        total++;
        if (stage_b !== 1'b1 || done_b !== 1'b1) begin
            bad++;
            $display("FAIL single_final: got stage=%0d done=%b want 1 1", stage_b, done_b);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_power_on();
        test_hold_gate();
        test_sw_reset();
        test_back_to_back();
        test_async_mid();
        test_single_domain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
